// File: rtl/iir_stereo_sched.sv
// Stereo scheduler that time-shares one FIFO-wrapped IIR datapath between ch0 (L) and ch1 (R).
// Optional build macro IIR_SCHED_STRICT_PAIR_EN forces strict L/R alternation instead of work-conserving round-robin.
module iir_stereo_sched #(
  parameter int DATA_WIDTH   = 32,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           in0_dout,
  input  logic                            in0_empty,
  output logic                            in0_rd_en,
  input  logic [DATA_WIDTH-1:0]           in1_dout,
  input  logic                            in1_empty,
  output logic                            in1_rd_en,
  output logic [DATA_WIDTH-1:0]           flt_din,
  output logic                            flt_wr_en,
  input  logic                            flt_full,
  input  logic [DATA_WIDTH-1:0]           flt_dout,
  input  logic                            flt_empty,
  output logic                            flt_rd_en,
  output logic [DATA_WIDTH-1:0]           out0_din,
  output logic                            out0_wr_en,
  input  logic                            out0_full,
  output logic [DATA_WIDTH-1:0]           out1_din,
  output logic                            out1_wr_en,
  input  logic                            out1_full,
  output logic [$clog2(MAX_INFLIGHT):0]   inflight,
  output logic                            err
);

  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int CW = PW + 1;

  logic [MAX_INFLIGHT-1:0] tag_q;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic                    rr_last;
  logic                    err_q;

  logic can_issue;
  logic grant_ok;
  logic grant_ch;
  logic grant;
  logic head_tag;
  logic q_nonempty;
  logic head_full;
  logic retire;
  logic discard;

  always_comb begin
    can_issue = !flt_full && (count < CW'(MAX_INFLIGHT));
`ifdef IIR_SCHED_STRICT_PAIR_EN
    // Only the channel opposite the last grant may go, keeping L/R sample-locked.
    grant_ch = ~rr_last;
    grant_ok = can_issue && (grant_ch ? !in1_empty : !in0_empty);
`else
    if (!in0_empty && !in1_empty) grant_ch = ~rr_last;
    else                          grant_ch = !in1_empty;
    grant_ok = can_issue && (!in0_empty || !in1_empty);
`endif
  end

  // Enables are gated by reset so they drop asynchronously with it.
  assign grant      = reset && grant_ok;
  assign q_nonempty = (count != '0);
  assign head_tag   = tag_q[rd_ptr];
  assign head_full  = head_tag ? out1_full : out0_full;
  assign retire     = reset && !flt_empty && q_nonempty && !head_full;
  assign discard    = reset && !flt_empty && !q_nonempty;

  assign in0_rd_en  = grant && !grant_ch;
  assign in1_rd_en  = grant && grant_ch;
  assign flt_wr_en  = grant;
  assign flt_din    = grant_ch ? in1_dout : in0_dout;

  assign flt_rd_en  = retire || discard;
  assign out0_wr_en = retire && !head_tag;
  assign out1_wr_en = retire && head_tag;
  assign out0_din   = flt_dout;
  assign out1_din   = flt_dout;

  assign inflight   = count;
  assign err        = err_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tag_q   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rr_last <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        tag_q[wr_ptr] <= grant_ch;
        wr_ptr        <= wr_ptr + PW'(1);
        rr_last       <= grant_ch;
      end
      if (retire) rd_ptr <= rd_ptr + PW'(1);
      if (grant && !retire)      count <= count + CW'(1);
      else if (!grant && retire) count <= count - CW'(1);
      if (discard) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_iir_stereo_sched.sv
// Bench for iir_stereo_sched: identity filter model, queue-based scheduler model, directed scenarios then random traffic.
module tb_iir_stereo_sched;
  localparam int DW = 32;
  localparam int MI = 16;
  localparam int CW = $clog2(MI) + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] in0_dout, in1_dout, flt_din, flt_dout, out0_din, out1_din;
  logic in0_empty, in1_empty, in0_rd_en, in1_rd_en, flt_wr_en, flt_full;
  logic flt_empty, flt_rd_en, out0_wr_en, out0_full, out1_wr_en, out1_full, err;
  logic [CW-1:0] inflight;

  always #5 clock = ~clock;

  iir_stereo_sched #(.DATA_WIDTH(DW), .MAX_INFLIGHT(MI)) dut (
    .clock(clock), .reset(reset),
    .in0_dout(in0_dout), .in0_empty(in0_empty), .in0_rd_en(in0_rd_en),
    .in1_dout(in1_dout), .in1_empty(in1_empty), .in1_rd_en(in1_rd_en),
    .flt_din(flt_din), .flt_wr_en(flt_wr_en), .flt_full(flt_full),
    .flt_dout(flt_dout), .flt_empty(flt_empty), .flt_rd_en(flt_rd_en),
    .out0_din(out0_din), .out0_wr_en(out0_wr_en), .out0_full(out0_full),
    .out1_din(out1_din), .out1_wr_en(out1_wr_en), .out1_full(out1_full),
    .inflight(inflight), .err(err)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] in_q0[$], in_q1[$];
  logic [DW-1:0] pipe_q[$];
  logic [DW-1:0] sb0[$], sb1[$];
  logic [DW-1:0] wr_log[$];
  logic [DW-1:0] out_log0[$], out_log1[$];
  int m_tags[$];
  int m_rr = 1;
  bit m_err = 0;

  bit rand_mode = 0;
  bit hold_out = 0;
  bit force_full0 = 0;
  bit inject = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_all();
    in_q0.delete(); in_q1.delete(); pipe_q.delete();
    sb0.delete(); sb1.delete(); wr_log.delete();
    out_log0.delete(); out_log1.delete(); m_tags.delete();
    m_rr = 1; m_err = 0; inject = 0;
  endtask

  // Called one step after a rising edge; asserts reset mid-cycle and checks the asynchronous clear.
  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    chk("rst_flt_wr_en", flt_wr_en, 0);
    chk("rst_in0_rd_en", in0_rd_en, 0);
    chk("rst_in1_rd_en", in1_rd_en, 0);
    chk("rst_flt_rd_en", flt_rd_en, 0);
    chk("rst_out0_wr_en", out0_wr_en, 0);
    chk("rst_out1_wr_en", out1_wr_en, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_err", err, 0);
    clear_all();
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  task automatic cycle();
    bit present, ready0, ready1, can, gr, ret, disc;
    int g, head;
    logic [DW-1:0] word;
    in0_empty = (in_q0.size() == 0);
    in1_empty = (in_q1.size() == 0);
    in0_dout  = in0_empty ? '0 : in_q0[0];
    in1_dout  = in1_empty ? '0 : in_q1[0];
    if (rand_mode) begin
      flt_full  = ($urandom_range(3) == 0);
      out0_full = ($urandom_range(3) == 0);
      out1_full = ($urandom_range(3) == 0);
      present   = ($urandom_range(3) != 0);
    end else begin
      flt_full  = 1'b0;
      out0_full = force_full0;
      out1_full = 1'b0;
      present   = !hold_out;
    end
    if (inject) begin
      flt_empty = 1'b0;
      flt_dout  = 32'hDEAD_BEEF;
    end else begin
      flt_empty = !(present && pipe_q.size() > 0);
      flt_dout  = flt_empty ? 32'h0 : pipe_q[0];
    end
    #2;
    ready0 = !in0_empty;
    ready1 = !in1_empty;
    can = !flt_full && (m_tags.size() < MI);
`ifdef IIR_SCHED_STRICT_PAIR_EN
    g  = 1 - m_rr;
    gr = can && (g == 1 ? ready1 : ready0);
`else
    if (ready0 && ready1) g = 1 - m_rr;
    else g = ready1 ? 1 : 0;
    gr = can && (ready0 || ready1);
`endif
    head = (m_tags.size() > 0) ? m_tags[0] : 0;
    ret  = !flt_empty && m_tags.size() > 0 && !(head == 1 ? out1_full : out0_full);
    disc = !flt_empty && m_tags.size() == 0;
    chk("flt_wr_en", flt_wr_en, gr);
    chk("in0_rd_en", in0_rd_en, gr && g == 0);
    chk("in1_rd_en", in1_rd_en, gr && g == 1);
    if (gr) chk("flt_din", flt_din, (g == 1) ? in_q1[0] : in_q0[0]);
    chk("flt_rd_en", flt_rd_en, ret || disc);
    chk("out0_wr_en", out0_wr_en, ret && head == 0);
    chk("out1_wr_en", out1_wr_en, ret && head == 1);
    if (ret && head == 0) chk("out0_din", out0_din, sb0[0]);
    if (ret && head == 1) chk("out1_din", out1_din, sb1[0]);
    chk("inflight", inflight, m_tags.size());
    chk("err", err, m_err);
    @(posedge clock); #1;
    if (ret) begin
      void'(pipe_q.pop_front());
      void'(m_tags.pop_front());
      if (head == 0) out_log0.push_back(sb0.pop_front());
      else           out_log1.push_back(sb1.pop_front());
    end
    if (disc) begin
      m_err = 1;
      inject = 0;
    end
    if (gr) begin
      word = (g == 1) ? in_q1.pop_front() : in_q0.pop_front();
      pipe_q.push_back(word);
      if (g == 1) sb1.push_back(word); else sb0.push_back(word);
      m_tags.push_back(g);
      m_rr = g;
      wr_log.push_back(word);
    end
    if (rand_mode) begin
      if (in_q0.size() < 4 && $urandom_range(1) == 1) in_q0.push_back($urandom);
      if (in_q1.size() < 4 && $urandom_range(1) == 1) in_q1.push_back($urandom);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [DW-1:0] exp_word;
    in0_dout = '0; in1_dout = '0; in0_empty = 1; in1_empty = 1;
    flt_full = 0; flt_dout = '0; flt_empty = 1; out0_full = 0; out1_full = 0;
    #1;
    do_reset();

    // Both channels loaded: alternating issue, identity filter returns each word to its own channel.
    for (int i = 0; i < 4; i++) begin
      in_q0.push_back(32'hA0 + i);
      in_q1.push_back(32'hB0 + i);
    end
    run(20);
    chk("t1_issue_count", wr_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      exp_word = (i % 2 == 0) ? 32'hA0 + i / 2 : 32'hB0 + i / 2;
      if (i < wr_log.size()) chk("t1_issue_order", wr_log[i], exp_word);
    end
    chk("t1_out0_count", out_log0.size(), 4);
    chk("t1_out1_count", out_log1.size(), 4);
    if (out_log0.size() == 4) chk("t1_out0_last", out_log0[3], 32'hA3);
    if (out_log1.size() == 4) chk("t1_out1_first", out_log1[0], 32'hB0);

    // ch1 empty, ch0 holds five words.
    do_reset();
    for (int i = 0; i < 5; i++) in_q0.push_back(32'hC0 + i);
    run(8);
`ifdef IIR_SCHED_STRICT_PAIR_EN
    chk("t2_issue_count", wr_log.size(), 1);
    in_q1.push_back(32'hD0);
    run(4);
    chk("t2_after_ch1", wr_log.size(), 3);
`else
    chk("t2_issue_count", wr_log.size(), 5);
`endif
    run(20);

    // Filter output held empty: issue saturates at MAX_INFLIGHT.
    do_reset();
    hold_out = 1;
    for (int i = 0; i < 10; i++) begin
      in_q0.push_back(32'h100 + i);
      in_q1.push_back(32'h200 + i);
    end
    run(25);
    chk("t3_issue_count", wr_log.size(), 16);
    chk("t3_inflight_lit", inflight, 16);
    chk("t3_no_wr", flt_wr_en, 0);
    hold_out = 0;
    run(40);
    chk("t3_drain_out0", out_log0.size(), 10);
    chk("t3_drain_out1", out_log1.size(), 10);

    // ch0 output full with ch0 at head: both channels stall, then drain in order.
    do_reset();
    force_full0 = 1;
    for (int i = 0; i < 3; i++) begin
      in_q0.push_back(32'h300 + i);
      in_q1.push_back(32'h400 + i);
    end
    run(10);
    chk("t4_stall_out0", out_log0.size(), 0);
    chk("t4_stall_out1", out_log1.size(), 0);
    chk("t4_inflight_lit", inflight, 6);
    force_full0 = 0;
    run(12);
    chk("t4_out0_count", out_log0.size(), 3);
    chk("t4_out1_count", out_log1.size(), 3);
    if (out_log0.size() == 3) chk("t4_out0_order", out_log0[2], 32'h302);

    // Stray filter word with nothing in flight.
    do_reset();
    inject = 1;
    cycle();
    chk("t5_err_lit", err, 1);
    run(5);
    chk("t5_err_sticky", err, 1);

    // Reset with seven samples in flight; ch0 must win the first grant afterwards.
    do_reset();
    hold_out = 1;
    for (int i = 0; i < 6; i++) begin
      in_q0.push_back(32'h500 + i);
      in_q1.push_back(32'h600 + i);
    end
    for (int i = 0; i < 20 && m_tags.size() < 7; i++) cycle();
    chk("t6_inflight_lit", inflight, 7);
    do_reset();
    hold_out = 0;
    in_q0.push_back(32'h700);
    in_q1.push_back(32'h800);
    cycle();
    chk("t6_first_grant", wr_log.size() > 0 ? wr_log[0] : 32'hFFFF_FFFF, 32'h700);
    run(10);

    // Random traffic with random backpressure on every interface.
    do_reset();
    rand_mode = 1;
    run(3000);
    rand_mode = 0;
    run(60);
    chk("rand_drained", m_tags.size() + in_q0.size() + in_q1.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
